logic_1b_vector_checker: RTL and testbench
==========================================

// Module: logic_1b_vector_checker
// PURPOSE
//   Self-checking stimulus engine for 2-input, 1-output gate cells (nand_1b and siblings).
//   Drives the gate inputs x/y through all four combinations, waits a settle time,
//   then samples the gate output o and compares it with a parameterised truth table.
//   Accumulates an error count and a per-vector fail mask, then reports done/pass.
//   Lets gate cells be checked in hardware or in any bench, with no $monitor inspection.
// PARAMETERS
//   TRUTH          4'b0111  expected o for vector v (v = {y,x}); bit v = expected; default = NAND
//   SETTLE_CYCLES  1        cycles each vector is held before o is sampled; legal range >= 1
//   PASSES         1        full 4-vector sweeps per run; legal range >= 1
//   ERR_W          4        width of err_count
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active high
//   start      in   1      begin a run; sampled only in IDLE or DONE
//   o          in   1      output of the gate under check
//   x          out  1      gate input x (registered), = v[0]
//   y          out  1      gate input y (registered), = v[1]
//   cur_vec    out  2      current vector index v
//   busy       out  1      high from the cycle after start until done rises
//   done       out  1      high in DONE; held until the next start or rst
//   pass       out  1      in DONE: (err_count == 0); otherwise 0
//   err_count  out  ERR_W  mismatches this run; saturates at 2^ERR_W-1
//   fail_vec   out  4      sticky mask; bit v set if vector v ever mismatched this run
// BEHAVIOUR
//   Reset (rst=1 at a clk edge, any state, including mid-run): state=IDLE; x=y=0; cur_vec=0;
//     busy=done=pass=0; err_count=0; fail_vec=0; settle counter and pass counter cleared.
//   FSM states: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
//   IDLE/DONE with start=1: v<=0, x<=0, y<=0, err_count<=0, fail_vec<=0, pass counter<=0,
//     done<=0, pass<=0, busy<=1, cnt<=0, go to SETTLE.
//   start while in SETTLE or CHECK: ignored.
//   SETTLE: if cnt==SETTLE_CYCLES-1 go to CHECK, else cnt<=cnt+1.
//   CHECK: compare o with TRUTH[v].
//     On mismatch: err_count<=sat(err_count+1) and fail_vec[v]<=1.
//     If v==3 and pass counter==PASSES-1: go to DONE, done<=1, busy<=0,
//       pass<=(no mismatch in this run, including this cycle).
//     Else: v<=v+1 (wraps 3->0); pass counter increments on the wrap;
//       x/y<=new v bits; cnt<=0; go to SETTLE.
//   Vector order per sweep: (x,y) = 00, 10, 01, 11.
//   x/y change only on the transition into SETTLE. They are stable during SETTLE and CHECK.
//   In DONE, x/y hold the last vector (1,1).
//   Latency: each vector takes SETTLE_CYCLES+1 cycles. done rises 4*PASSES*(SETTLE_CYCLES+1)+1
//     cycles after the edge that sampled start (9 cycles at the defaults).
//   Saturation: err_count never wraps. fail_vec reflects every mismatch even after err_count saturates.
//   Restart from DONE with start=1 clears all results in the same edge, as from IDLE.
// TESTING
//   1 Defaults, o driven by a correct NAND model, start pulse -> done at +9 cycles,
//     pass=1, err_count=0, fail_vec=0000, x/y sequence 00,10,01,11.
//   2 Defaults, o stuck at 1 -> done, pass=0, err_count=1, fail_vec=1000.
//   3 TRUTH=4'b1000 (AND), o from a NAND model -> err_count=4, fail_vec=1111, pass=0.
//   4 PASSES=5, ERR_W=4, o stuck at 0 on a NAND check -> 15 mismatches,
//     err_count=15, not wrapped, fail_vec=0111.
//   5 SETTLE_CYCLES=3, correct DUT -> x/y held 4 cycles per vector, done at +17 cycles,
//     pass=1; extra start pulses while busy have no effect.
//   6 rst asserted while in CHECK of v=2 -> next cycle IDLE with all outputs at reset values.
//     A new start then runs a full, clean sweep with pass=1.

Source files
------------

// File: rtl/logic_1b_vector_checker.sv
// Sweeps a 2-input gate through all four input vectors, samples its output after a settle
// time, and compares it with TRUTH; results are held in DONE until restart or reset.
module logic_1b_vector_checker #(
    parameter logic [3:0] TRUTH         = 4'b0111,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         PASSES        = 1,
    parameter int         ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             o,
    output logic             x,
    output logic             y,
    output logic [1:0]       cur_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   pcnt, pcnt_n;
    logic [1:0]      vec_n, vec_inc;
    logic            x_n, y_n, busy_n, done_n, pass_n, mism;
    logic [ERR_W-1:0] err_n;
    logic [3:0]      fail_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        vec_n   = cur_vec;
        x_n     = x;
        y_n     = y;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_count;
        fail_n  = fail_vec;
        mism    = 1'b0;
        vec_inc = cur_vec + 2'd1;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    pcnt_n  = '0;
                    vec_n   = 2'd0;
                    x_n     = 1'b0;
                    y_n     = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    fail_n  = 4'b0000;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) state_n = CHECK;
                else                 cnt_n   = cnt + 1'b1;
            end
            CHECK: begin
                mism = (o != TRUTH[cur_vec]);
                if (mism) begin
                    // Saturate rather than wrap so a non-zero count can never read as clean
                    if (err_count != {ERR_W{1'b1}}) err_n = err_count + 1'b1;
                    fail_n = fail_vec | (4'b0001 << cur_vec);
                end
                if (cur_vec == 2'd3 && pcnt == PASS_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    pass_n  = (err_count == '0) && !mism;
                end else begin
                    state_n = SETTLE;
                    vec_n   = vec_inc;
                    x_n     = vec_inc[0];
                    y_n     = vec_inc[1];
                    cnt_n   = '0;
                    if (cur_vec == 2'd3) pcnt_n = pcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pcnt      <= '0;
            cur_vec   <= 2'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'b0000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pcnt      <= pcnt_n;
            cur_vec   <= vec_n;
            x         <= x_n;
            y         <= y_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            fail_vec  <= fail_n;
        end
    end

endmodule

// File: tb/tb_logic_1b_vector_checker.sv
// Directed bench: four checker instances (default, AND truth table, 5 passes, 3-cycle settle)
// each driving a NAND model or a stuck-at output.
module tb_logic_1b_vector_checker;

    logic       clk = 1'b0;
    logic       rst [4];
    logic       start [4];
    logic       o_w [4];
    int         mode [4];            // 0: NAND model, 1: stuck at 1, 2: stuck at 0
    logic       x_w [4];
    logic       y_w [4];
    logic [1:0] cv_w [4];
    logic       busy_w [4];
    logic       done_w [4];
    logic       pass_w [4];
    logic [3:0] ec_w [4];
    logic [3:0] fv_w [4];

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] seq [64];            // recorded {x,y} per held vector
    int         hold [64];
    int         nseq;
    logic       snap_done;
    logic [3:0] snap_ec, snap_fv;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                1:       o_w[i] = 1'b1;
                2:       o_w[i] = 1'b0;
                default: o_w[i] = ~(x_w[i] & y_w[i]);
            endcase
        end
    end

    logic_1b_vector_checker u_def (
        .clk(clk), .rst(rst[0]), .start(start[0]), .o(o_w[0]), .x(x_w[0]), .y(y_w[0]),
        .cur_vec(cv_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(ec_w[0]), .fail_vec(fv_w[0]));

    logic_1b_vector_checker #(.TRUTH(4'b1000)) u_and (
        .clk(clk), .rst(rst[1]), .start(start[1]), .o(o_w[1]), .x(x_w[1]), .y(y_w[1]),
        .cur_vec(cv_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(ec_w[1]), .fail_vec(fv_w[1]));

    logic_1b_vector_checker #(.PASSES(5), .ERR_W(4)) u_p5 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .o(o_w[2]), .x(x_w[2]), .y(y_w[2]),
        .cur_vec(cv_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(ec_w[2]), .fail_vec(fv_w[2]));

    logic_1b_vector_checker #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst(rst[3]), .start(start[3]), .o(o_w[3]), .x(x_w[3]), .y(y_w[3]),
        .cur_vec(cv_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .err_count(ec_w[3]), .fail_vec(fv_w[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, ".x"},    32'(x_w[i]),    32'd0);
        chk({tag, ".y"},    32'(y_w[i]),    32'd0);
        chk({tag, ".vec"},  32'(cv_w[i]),   32'd0);
        chk({tag, ".busy"}, 32'(busy_w[i]), 32'd0);
        chk({tag, ".done"}, 32'(done_w[i]), 32'd0);
        chk({tag, ".pass"}, 32'(pass_w[i]), 32'd0);
        chk({tag, ".err"},  32'(ec_w[i]),   32'd0);
        chk({tag, ".fail"}, 32'(fv_w[i]),   32'd0);
    endtask

    // Pulses start, then counts edges (the start-sampling edge is edge 1) until done is seen,
    // recording each distinct {x,y} and how many cycles it was held.
    task automatic run(input int i, input int budget, input bit extra, output int lat);
        logic [1:0] cur;
        nseq = 0;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        lat = 1;
        snap_done = done_w[i];
        snap_ec   = ec_w[i];
        snap_fv   = fv_w[i];
        while (!done_w[i] && lat < budget) begin
            cur = {x_w[i], y_w[i]};
            if (nseq == 0 || cur != seq[nseq-1]) begin
                if (nseq < 64) begin
                    seq[nseq]  = cur;
                    hold[nseq] = 1;
                    nseq++;
                end
            end else begin
                hold[nseq-1]++;
            end
            start[i] = extra && (lat == 3 || lat == 6 || lat == 8);
            step();
            lat++;
        end
        start[i] = 1'b0;
        if (!done_w[i]) chk("done_timeout", 32'(lat), 32'(budget + 1));
    endtask

    initial begin
        int lat;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b00; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; mode[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        chk_idle(0, "reset");

        // 1: clean NAND sweep
        run(0, 50, 1'b0, lat);
        chk("t1.lat",  32'(lat),       32'd9);
        chk("t1.done", 32'(done_w[0]), 32'd1);
        chk("t1.pass", 32'(pass_w[0]), 32'd1);
        chk("t1.busy", 32'(busy_w[0]), 32'd0);
        chk("t1.err",  32'(ec_w[0]),   32'd0);
        chk("t1.fail", 32'(fv_w[0]),   32'd0);
        chk("t1.nseq", 32'(nseq),      32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1.xy%0d", k),   32'(seq[k]),  32'(exp_seq[k]));
            chk($sformatf("t1.hold%0d", k), 32'(hold[k]), 32'd2);
        end
        repeat (3) step();
        chk("t1.done_hold", 32'(done_w[0]),        32'd1);
        chk("t1.xy_hold",   32'({x_w[0], y_w[0]}), 32'b11);

        // 2: stuck at 1, restart from DONE
        mode[0] = 1;
        run(0, 50, 1'b0, lat);
        chk("t2.restart_done", 32'(snap_done), 32'd0);
        chk("t2.lat",  32'(lat),       32'd9);
        chk("t2.pass", 32'(pass_w[0]), 32'd0);
        chk("t2.err",  32'(ec_w[0]),   32'd1);
        chk("t2.fail", 32'(fv_w[0]),   32'b1000);

        // 3: AND truth table against a NAND gate
        run(1, 50, 1'b0, lat);
        chk("t3.err",  32'(ec_w[1]),   32'd4);
        chk("t3.fail", 32'(fv_w[1]),   32'b1111);
        chk("t3.pass", 32'(pass_w[1]), 32'd0);

        // 4: five passes, stuck at 0
        mode[2] = 2;
        run(2, 100, 1'b0, lat);
        chk("t4.lat",  32'(lat),       32'd41);
        chk("t4.nseq", 32'(nseq),      32'd20);
        chk("t4.err",  32'(ec_w[2]),   32'd15);
        chk("t4.fail", 32'(fv_w[2]),   32'b0111);
        chk("t4.pass", 32'(pass_w[2]), 32'd0);

        // 5: three-cycle settle, extra start pulses while busy
        run(3, 60, 1'b1, lat);
        chk("t5.lat",  32'(lat),       32'd17);
        chk("t5.pass", 32'(pass_w[3]), 32'd1);
        chk("t5.nseq", 32'(nseq),      32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5.xy%0d", k),   32'(seq[k]),  32'(exp_seq[k]));
            chk($sformatf("t5.hold%0d", k), 32'(hold[k]), 32'd4);
        end

        // 6: reset during CHECK of v=2 (sixth edge after start), then a clean rerun
        mode[0] = 0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (5) step();
        chk("t6.vec",  32'(cv_w[0]),   32'd2);
        chk("t6.busy", 32'(busy_w[0]), 32'd1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk_idle(0, "t6.rst");
        repeat (2) step();
        chk("t6.idle_busy", 32'(busy_w[0]), 32'd0);
        run(0, 50, 1'b0, lat);
        chk("t6.restart_err",  32'(snap_ec),    32'd0);
        chk("t6.restart_fail", 32'(snap_fv),    32'd0);
        chk("t6.lat",          32'(lat),        32'd9);
        chk("t6.pass",         32'(pass_w[0]),  32'd1);
        chk("t6.err",          32'(ec_w[0]),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
